// File: rtl/i2c_slave_controller.sv
// i2c_slave_controller: byte-level I2C target that decodes address, pointer and data bytes,
// drives the target ACK bit and feeds read bytes to the bus interface. Optional: I2C_GENERAL_CALL_EN.
module i2c_slave_controller #(
    parameter logic [6:0] DEV_ADDR = 7'h40,
    parameter int         NUM_REGS = 16,
    parameter int         ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              scl_i,
    input  logic              sda_i,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    input  logic              start_i,
    input  logic              stop_i,
    output logic [7:0]        tx_data,
    output logic              tx_req,
    input  logic              tx_ready,
    output logic              ack_drive_o,
    output logic [ADDR_W-1:0] reg_addr,
    output logic [7:0]        reg_wdata,
    output logic              reg_we,
    input  logic [7:0]        reg_rdata,
    output logic              soft_reset_o
);

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_DEV_ADDR  = 4'd1,
        ST_REG_PTR   = 4'd2,
        ST_WR_DATA   = 4'd3,
        ST_RD_LOAD   = 4'd4,
        ST_RD_SHIFT  = 4'd5,
        ST_RD_MACK   = 4'd6,
        ST_WAIT_STOP = 4'd7,
        ST_GC_CMD    = 4'd8
    } state_t;

    typedef enum logic [1:0] {
        ACK_NONE  = 2'd0,
        ACK_ARMED = 2'd1,
        ACK_DRIVE = 2'd2
    } ack_t;

    state_t            state_r, state_s;
    ack_t              ack_r, ack_s;
    logic [ADDR_W-1:0] ptr_r, ptr_s;
    logic              scl_prev_r, tx_ready_prev_r;
    logic              mack_ok_r, mack_ok_s;
    logic              ack_drive_r, ack_drive_s;
    logic              tx_req_r, tx_req_s;
    logic [7:0]        tx_data_r, tx_data_s;
    logic              reg_we_r, reg_we_s;
    logic [7:0]        reg_wdata_r, reg_wdata_s;
    logic              load_s;
`ifdef I2C_GENERAL_CALL_EN
    logic              soft_reset_r, soft_reset_s;
`endif

    logic scl_fall_s, scl_rise_s, tx_rdy_rise_s, load_go_s;
    assign scl_fall_s    = scl_prev_r & ~scl_i;
    assign scl_rise_s    = ~scl_prev_r & scl_i;
    assign tx_rdy_rise_s = ~tx_ready_prev_r & tx_ready;
    // A read load may go once the address ACK has been released (or on the releasing edge itself).
    assign load_go_s     = tx_ready & ((ack_r == ACK_NONE) | ((ack_r == ACK_DRIVE) & scl_fall_s));

    // Next-state, ACK window and output decode.
    always_comb begin
        state_s     = state_r;
        ack_s       = ack_r;
        ack_drive_s = ack_drive_r;
        ptr_s       = reg_we_r ? (ptr_r + ADDR_W'(1)) : ptr_r;
        mack_ok_s   = mack_ok_r;
        tx_req_s    = 1'b0;
        tx_data_s   = tx_data_r;
        reg_we_s    = 1'b0;
        reg_wdata_s = reg_wdata_r;
        load_s      = 1'b0;
`ifdef I2C_GENERAL_CALL_EN
        soft_reset_s = 1'b0;
`endif

        case (ack_r)
            ACK_ARMED: begin
                if (scl_fall_s) begin
                    ack_s       = ACK_DRIVE;
                    ack_drive_s = 1'b1;
                end else begin
                    ack_s = ACK_ARMED;
                end
            end
            ACK_DRIVE: begin
                if (scl_fall_s) begin
                    ack_s       = ACK_NONE;
                    ack_drive_s = 1'b0;
                end else begin
                    ack_s = ACK_DRIVE;
                end
            end
            default: begin
                ack_s       = ACK_NONE;
                ack_drive_s = 1'b0;
            end
        endcase

        if (stop_i) begin
            state_s     = ST_IDLE;
            ack_s       = ACK_NONE;
            ack_drive_s = 1'b0;
            mack_ok_s   = 1'b0;
        end else if (start_i) begin
            state_s     = ST_DEV_ADDR;
            ack_s       = ACK_NONE;
            ack_drive_s = 1'b0;
            mack_ok_s   = 1'b0;
        end else begin
            case (state_r)
                ST_DEV_ADDR: begin
                    if (rx_valid) begin
                        if (rx_data[7:1] == DEV_ADDR) begin
                            ack_s   = ACK_ARMED;
                            state_s = rx_data[0] ? ST_RD_LOAD : ST_REG_PTR;
`ifdef I2C_GENERAL_CALL_EN
                        end else if (rx_data == 8'h00) begin
                            ack_s   = ACK_ARMED;
                            state_s = ST_GC_CMD;
`endif
                        end else begin
                            state_s = ST_WAIT_STOP;
                        end
                    end else begin
                        state_s = ST_DEV_ADDR;
                    end
                end
                ST_REG_PTR: begin
                    if (rx_valid) begin
                        ptr_s   = rx_data[ADDR_W-1:0];
                        ack_s   = ACK_ARMED;
                        state_s = ST_WR_DATA;
                    end else begin
                        state_s = ST_REG_PTR;
                    end
                end
                ST_WR_DATA: begin
                    // Pointer advances the cycle after the strobe so reg_addr holds during reg_we.
                    if (rx_valid) begin
                        reg_we_s    = 1'b1;
                        reg_wdata_s = rx_data;
                        ack_s       = ACK_ARMED;
                    end else begin
                        state_s = ST_WR_DATA;
                    end
                end
                ST_RD_LOAD: begin
                    load_s = load_go_s;
                end
                ST_RD_SHIFT: begin
                    if (tx_rdy_rise_s) begin
                        state_s   = ST_RD_MACK;
                        mack_ok_s = 1'b0;
                    end else begin
                        state_s = ST_RD_SHIFT;
                    end
                end
                ST_RD_MACK: begin
                    if (mack_ok_r) begin
                        if (scl_fall_s) begin
                            mack_ok_s = 1'b0;
                            if (tx_ready) begin
                                load_s = 1'b1;
                            end else begin
                                state_s = ST_RD_LOAD;
                            end
                        end else begin
                            state_s = ST_RD_MACK;
                        end
                    end else if (scl_rise_s) begin
                        if (sda_i) begin
                            state_s = ST_WAIT_STOP;
                        end else begin
                            mack_ok_s = 1'b1;
                        end
                    end else begin
                        state_s = ST_RD_MACK;
                    end
                end
`ifdef I2C_GENERAL_CALL_EN
                ST_GC_CMD: begin
                    if (rx_valid) begin
                        state_s = ST_WAIT_STOP;
                        if (rx_data == 8'h06) begin
                            ack_s        = ACK_ARMED;
                            soft_reset_s = 1'b1;
                            ptr_s        = {ADDR_W{1'b0}};
                        end else begin
                            ack_s = ack_r;
                        end
                    end else begin
                        state_s = ST_GC_CMD;
                    end
                end
`endif
                default: begin
                    state_s = state_r;
                end
            endcase
        end

        if (load_s) begin
            tx_req_s  = 1'b1;
            tx_data_s = reg_rdata;
            ptr_s     = ptr_r + ADDR_W'(1);
            state_s   = ST_RD_SHIFT;
        end else begin
            tx_req_s = 1'b0;
        end
    end

    // State and registered-output update.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r         <= ST_IDLE;
            ack_r           <= ACK_NONE;
            ptr_r           <= {ADDR_W{1'b0}};
            scl_prev_r      <= 1'b1;
            tx_ready_prev_r <= 1'b1;
            mack_ok_r       <= 1'b0;
            ack_drive_r     <= 1'b0;
            tx_req_r        <= 1'b0;
            tx_data_r       <= 8'h00;
            reg_we_r        <= 1'b0;
            reg_wdata_r     <= 8'h00;
`ifdef I2C_GENERAL_CALL_EN
            soft_reset_r    <= 1'b0;
`endif
        end else begin
            state_r         <= state_s;
            ack_r           <= ack_s;
            ptr_r           <= ptr_s;
            scl_prev_r      <= scl_i;
            tx_ready_prev_r <= tx_ready;
            mack_ok_r       <= mack_ok_s;
            ack_drive_r     <= ack_drive_s;
            tx_req_r        <= tx_req_s;
            tx_data_r       <= tx_data_s;
            reg_we_r        <= reg_we_s;
            reg_wdata_r     <= reg_wdata_s;
`ifdef I2C_GENERAL_CALL_EN
            soft_reset_r    <= soft_reset_s;
`endif
        end
    end

    assign tx_data     = tx_data_r;
    assign tx_req      = tx_req_r;
    assign ack_drive_o = ack_drive_r;
    assign reg_addr    = ptr_r;
    assign reg_wdata   = reg_wdata_r;
    assign reg_we      = reg_we_r;
`ifdef I2C_GENERAL_CALL_EN
    assign soft_reset_o = soft_reset_r;
`else
    assign soft_reset_o = 1'b0;
`endif

endmodule

// File: tb/tb_i2c_slave_controller.sv
// Directed bench for i2c_slave_controller: table of write transactions plus hand-written
// read, abort, collision, reset and general-call sequences.
module tb_i2c_slave_controller;

    logic       clk, reset, scl_i, sda_i, rx_valid, start_i, stop_i, tx_ready;
    logic [7:0] rx_data, tx_data, reg_wdata, reg_rdata;
    logic       tx_req, ack_drive_o, reg_we, soft_reset_o;
    logic [3:0] reg_addr;
    logic       preload;
    logic [7:0] mem [16];

    int n_checks = 0;
    int n_fail   = 0;

    i2c_slave_controller dut (
        .clk(clk), .reset(reset), .scl_i(scl_i), .sda_i(sda_i),
        .rx_data(rx_data), .rx_valid(rx_valid), .start_i(start_i), .stop_i(stop_i),
        .tx_data(tx_data), .tx_req(tx_req), .tx_ready(tx_ready), .ack_drive_o(ack_drive_o),
        .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_we(reg_we),
        .reg_rdata(reg_rdata), .soft_reset_o(soft_reset_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file: combinational read, write on strobe, preload to A0+i.
    assign reg_rdata = mem[reg_addr];
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 16; i++) mem[i] <= 8'hA0 + 8'(i);
        end else if (reg_we) begin
            mem[reg_addr] <= reg_wdata;
        end
    end

    // Event monitor sampled on the falling clock edge.
    int         ack_cnt = 0, we_cnt = 0, tx_cnt = 0, sr_cnt = 0;
    logic       ack_prev = 1'b0;
    logic [3:0] we_addr_log [8];
    logic [7:0] we_data_log [8];
    logic [7:0] tx_log [8];
    always @(negedge clk) begin
        ack_prev <= ack_drive_o;
        if (ack_drive_o && !ack_prev) ack_cnt <= ack_cnt + 1;
        if (reg_we) begin
            we_addr_log[we_cnt % 8] <= reg_addr;
            we_data_log[we_cnt % 8] <= reg_wdata;
            we_cnt <= we_cnt + 1;
        end
        if (tx_req) begin
            tx_log[tx_cnt % 8] <= tx_data;
            tx_cnt <= tx_cnt + 1;
        end
        if (soft_reset_o) sr_cnt <= sr_cnt + 1;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic start_pulse();
        scl_i = 1'b1; start_i = 1'b1; tick(1); start_i = 1'b0; tick(1);
    endtask

    // Eight data bits, rx_valid, then the ACK bit clock (falling edge arms the target ACK).
    task automatic send_byte(input logic [7:0] b);
        for (int i = 0; i < 8; i++) begin
            scl_i = 1'b0; tick(2); scl_i = 1'b1; tick(2);
        end
        rx_data = b; rx_valid = 1'b1; tick(1); rx_valid = 1'b0;
        scl_i = 1'b0; tick(2); scl_i = 1'b1; tick(2);
    endtask

    task automatic stop_seq();
        scl_i = 1'b0; tick(2); scl_i = 1'b1; tick(2);
        stop_i = 1'b1; tick(1); stop_i = 1'b0; tick(3);
    endtask

    task automatic rstart_seq();
        scl_i = 1'b0; tick(2); scl_i = 1'b1; tick(2);
        start_pulse();
    endtask

    // Target shifts out a byte, bus interface returns ready, master answers with ACK/NACK.
    task automatic master_ack_byte(input logic nack);
        for (int i = 0; i < 8; i++) begin
            tick(1); scl_i = 1'b1; tick(2); scl_i = 1'b0; tick(1);
        end
        tx_ready = 1'b1; tick(1);
        sda_i = nack; scl_i = 1'b1; tick(2);
        scl_i = 1'b0; tick(1);
    endtask

    typedef struct {
        logic [7:0] a, p, d;
        int         exp_ack, exp_we;
        logic [3:0] exp_waddr;
        logic [7:0] exp_wdata;
        logic [3:0] exp_ptr;
    } wr_vec_t;

    wr_vec_t vecs [6];
    int b_ack, b_we, b_tx, b_sr;

    initial begin
        vecs[0] = '{8'h80, 8'h03, 8'hAA, 3, 1, 4'h3, 8'hAA, 4'h4};
        vecs[1] = '{8'h80, 8'h1F, 8'h11, 3, 1, 4'hF, 8'h11, 4'h0};
        vecs[2] = '{8'h90, 8'h01, 8'h22, 0, 0, 4'h0, 8'h00, 4'h0};
        vecs[3] = '{8'h80, 8'h07, 8'h5A, 3, 1, 4'h7, 8'h5A, 4'h8};
        vecs[4] = '{8'h82, 8'h04, 8'h33, 0, 0, 4'h0, 8'h00, 4'h8};
        vecs[5] = '{8'h80, 8'h12, 8'hC3, 3, 1, 4'h2, 8'hC3, 4'h3};

        reset = 1'b1; scl_i = 1'b1; sda_i = 1'b1; rx_data = 8'h00; rx_valid = 1'b0;
        start_i = 1'b0; stop_i = 1'b0; tx_ready = 1'b1; preload = 1'b1;
        tick(3);
        check("reset tx_req", {31'd0, tx_req}, 32'd0);
        check("reset tx_data", {24'd0, tx_data}, 32'd0);
        check("reset ack_drive", {31'd0, ack_drive_o}, 32'd0);
        check("reset reg_addr", {28'd0, reg_addr}, 32'd0);
        check("reset reg_we", {31'd0, reg_we}, 32'd0);
        check("reset reg_wdata", {24'd0, reg_wdata}, 32'd0);
        check("reset soft_reset", {31'd0, soft_reset_o}, 32'd0);
        reset = 1'b0; preload = 1'b0; tick(2);

        // Table of single-byte write transactions.
        for (int v = 0; v < 6; v++) begin
            b_ack = ack_cnt; b_we = we_cnt;
            start_pulse();
            send_byte(vecs[v].a); send_byte(vecs[v].p); send_byte(vecs[v].d);
            stop_seq();
            check($sformatf("vec%0d ack windows", v), ack_cnt - b_ack, vecs[v].exp_ack);
            check($sformatf("vec%0d write count", v), we_cnt - b_we, vecs[v].exp_we);
            check($sformatf("vec%0d pointer", v), {28'd0, reg_addr}, {28'd0, vecs[v].exp_ptr});
            if (vecs[v].exp_we == 1) begin
                check($sformatf("vec%0d write addr", v), {28'd0, we_addr_log[b_we % 8]}, {28'd0, vecs[v].exp_waddr});
                check($sformatf("vec%0d write data", v), {24'd0, we_data_log[b_we % 8]}, {24'd0, vecs[v].exp_wdata});
            end
        end

        // Two-byte burst write.
        b_ack = ack_cnt; b_we = we_cnt;
        start_pulse();
        send_byte(8'h80); send_byte(8'h03); send_byte(8'hAA); send_byte(8'h55);
        stop_seq();
        check("burst ack windows", ack_cnt - b_ack, 32'd4);
        check("burst write count", we_cnt - b_we, 32'd2);
        check("burst wr0 addr", {28'd0, we_addr_log[b_we % 8]}, 32'h3);
        check("burst wr0 data", {24'd0, we_data_log[b_we % 8]}, 32'hAA);
        check("burst wr1 addr", {28'd0, we_addr_log[(b_we + 1) % 8]}, 32'h4);
        check("burst wr1 data", {24'd0, we_data_log[(b_we + 1) % 8]}, 32'h55);
        check("burst pointer", {28'd0, reg_addr}, 32'h5);

        // Read with pointer wrap: reg[15] then reg[0], master ACK then NACK.
        preload = 1'b1; tick(1); preload = 1'b0;
        b_ack = ack_cnt; b_tx = tx_cnt;
        start_pulse();
        send_byte(8'h80); send_byte(8'h0F);
        rstart_seq();
        send_byte(8'h81);
        scl_i = 1'b0; tick(1); tick(1); tx_ready = 1'b0;
        master_ack_byte(1'b0);
        tick(1); tx_ready = 1'b0;
        master_ack_byte(1'b1);
        tick(3);
        check("read tx_req count", tx_cnt - b_tx, 32'd2);
        check("read byte0", {24'd0, tx_log[b_tx % 8]}, 32'hAF);
        check("read byte1", {24'd0, tx_log[(b_tx + 1) % 8]}, 32'hA0);
        check("read pointer", {28'd0, reg_addr}, 32'h1);
        rx_data = 8'h80; rx_valid = 1'b1; tick(1); rx_valid = 1'b0;
        scl_i = 1'b1; tick(2); scl_i = 1'b0; tick(2); scl_i = 1'b1; tick(2); scl_i = 1'b0; tick(2);
        check("read ack windows (WAIT_STOP ignores rx)", ack_cnt - b_ack, 32'd3);
        check("read no extra tx_req", tx_cnt - b_tx, 32'd2);
        sda_i = 1'b1; tx_ready = 1'b1;
        stop_seq();

        // STOP inside the fourth bit of the first data byte.
        b_ack = ack_cnt; b_we = we_cnt;
        start_pulse();
        send_byte(8'h80); send_byte(8'h02);
        for (int i = 0; i < 3; i++) begin
            scl_i = 1'b0; tick(2); scl_i = 1'b1; tick(2);
        end
        scl_i = 1'b0; tick(2); scl_i = 1'b1; tick(1);
        stop_i = 1'b1; tick(1); stop_i = 1'b0; tick(2);
        rx_data = 8'h80; rx_valid = 1'b1; tick(1); rx_valid = 1'b0;
        scl_i = 1'b0; tick(2); scl_i = 1'b1; tick(2); scl_i = 1'b0; tick(2); scl_i = 1'b1; tick(3);
        check("stop-mid ack windows", ack_cnt - b_ack, 32'd2);
        check("stop-mid no write", we_cnt - b_we, 32'd0);
        check("stop-mid pointer", {28'd0, reg_addr}, 32'h2);

        // start_i and rx_valid together in WR_DATA: START wins, then a fresh write header.
        b_ack = ack_cnt; b_we = we_cnt;
        start_pulse();
        send_byte(8'h80); send_byte(8'h05);
        scl_i = 1'b0; tick(2); scl_i = 1'b1; tick(2);
        rx_data = 8'h33; rx_valid = 1'b1; start_i = 1'b1; tick(1);
        rx_valid = 1'b0; start_i = 1'b0; tick(3);
        check("collision no write", we_cnt - b_we, 32'd0);
        send_byte(8'h80); send_byte(8'h06);
        stop_seq();
        check("collision ack windows", ack_cnt - b_ack, 32'd4);
        check("collision pointer", {28'd0, reg_addr}, 32'h6);
        check("collision still no write", we_cnt - b_we, 32'd0);

        // Reset asserted while the target is shifting a read byte.
        b_tx = tx_cnt;
        start_pulse();
        send_byte(8'h80); send_byte(8'h09);
        rstart_seq();
        send_byte(8'h81);
        scl_i = 1'b0; tick(1); tick(1); tx_ready = 1'b0;
        scl_i = 1'b1; tick(2); scl_i = 1'b0; tick(2);
        check("pre-reset tx_req count", tx_cnt - b_tx, 32'd1);
        check("pre-reset pointer", {28'd0, reg_addr}, 32'hA);
        reset = 1'b1; tick(1);
        check("mid reset tx_req", {31'd0, tx_req}, 32'd0);
        check("mid reset ack_drive", {31'd0, ack_drive_o}, 32'd0);
        check("mid reset pointer", {28'd0, reg_addr}, 32'h0);
        check("mid reset reg_we", {31'd0, reg_we}, 32'd0);
        reset = 1'b0; scl_i = 1'b1; tx_ready = 1'b1; tick(4);
        check("post reset no tx_req", tx_cnt - b_tx, 32'd1);

        // General call reset.
        b_ack = ack_cnt; b_sr = sr_cnt;
        start_pulse();
        send_byte(8'h00); send_byte(8'h06);
        stop_seq();
`ifdef I2C_GENERAL_CALL_EN
        check("gc ack windows", ack_cnt - b_ack, 32'd2);
        check("gc soft_reset cycles", sr_cnt - b_sr, 32'd1);
`else
        check("gc ack windows", ack_cnt - b_ack, 32'd0);
        check("gc soft_reset cycles", sr_cnt - b_sr, 32'd0);
`endif
        check("gc pointer", {28'd0, reg_addr}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
